// File: rtl/alu_controller.sv
// Command-driven controller for an external combinational ALU with a 4-entry register file.
// Each command runs IDLE -> ISSUE -> RESPOND; the result is written back and returned on the response port.
`timescale 1ns/1ps

module alu_controller #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_dst,
  input  logic [1:0]        cmd_src_a,
  input  logic [1:0]        cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_in3,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [1:0] OP_LDI = 2'd3;

  state_t            state;
  state_t            state_next;
  logic [1:0]        op_q;
  logic [1:0]        dst_q;
  logic [1:0]        src_a_q;
  logic [1:0]        src_b_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] wr_value;

  // LDI bypasses the ALU entirely so its result never depends on alu_result.
  assign wr_value = (op_q == OP_LDI) ? imm_q : alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_in3    = '0;
    alu_op     = 2'd0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        alu_in1    = regs[src_a_q];
        alu_in2    = regs[src_b_q];
        alu_in3    = imm_q;
        alu_op     = (op_q == OP_LDI) ? 2'd0 : op_q;
        state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 2'd0;
      dst_q   <= 2'd0;
      src_a_q <= 2'd0;
      src_b_q <= 2'd0;
      imm_q   <= '0;
    end else if (state == IDLE && cmd_valid) begin
      op_q    <= cmd_op;
      dst_q   <= cmd_dst;
      src_a_q <= cmd_src_a;
      src_b_q <= cmd_src_b;
      imm_q   <= cmd_imm;
    end
  end

  // Sources are read combinationally during ISSUE, so a dst==src write lands only for the next command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ISSUE) begin
      regs[dst_q] <= wr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_data <= wr_value;
      rsp_zero <= (wr_value == '0);
    end
  end

endmodule
